branch_resolver: RTL
====================

Name: branch_resolver

Overview:
- Consumer and driver of the branch comparator interface.
- Drives BrUn from the branch funct3 and reads back BrEq/BrLt.
- Resolves the branch outcome, trains a table of 2-bit saturating predictors indexed by PC, and raises a registered flush/redirect on misprediction.
- Sits between fetch (prediction lookup) and execute (resolution) of the RISC-V core.

Parameters:
IDX_BITS, 6, log2 of predictor table entries (64 entries)
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
pred_pc  in  32  fetch-stage PC to predict
pred_taken  out  1  prediction for pred_pc, combinational table read
res_valid  in  1  a branch is resolving this cycle
res_pc  in  32  PC of the resolving branch
res_funct3  in  3  branch funct3
res_pred_taken  in  1  prediction originally issued for this branch
res_target  in  32  branch target address
BrUn  out  1  unsigned-compare select to comparator, combinational
BrEq  in  1  comparator equal flag
BrLt  in  1  comparator less-than flag
flush  out  1  one-cycle mispredict pulse, registered
redirect_pc  out  32  corrected PC, valid while flush=1
illegal_br  out  1  one-cycle pulse for funct3 010/011, registered
br_count  out  CNT_W  resolved legal branches, saturating
mispred_count  out  CNT_W  mispredictions, saturating

Behaviour:
- All state is clocked on the rising edge of clk. rst_n is sampled synchronously.
- Reset: every table entry = 2'b01 (weakly not-taken). flush=0, redirect_pc=0, illegal_br=0, br_count=0, mispred_count=0.
- Reset has priority over any res_valid in the same cycle.
- Index: pred_pc[IDX_BITS+1:2] for lookup, res_pc[IDX_BITS+1:2] for update. pc[1:0] is ignored.
- pred_taken = MSB of the indexed entry.
- BrUn = 1 when res_funct3 is 110 or 111, else 0. It is independent of res_valid.
- Actual outcome by funct3:
  - 000 beq: BrEq
  - 001 bne: !BrEq
  - 100 blt: BrLt
  - 101 bge: !BrLt
  - 110 bltu: BrLt
  - 111 bgeu: !BrLt
- funct3 010/011 with res_valid=1: illegal_br=1 next cycle. There is no table update, no counter change and no flush.
- Legal res_valid=1, table update at the clock edge:
  - taken: entry increments, saturating at 11.
  - not taken: entry decrements, saturating at 00.
- Legal res_valid=1, statistics: br_count increments, saturating at all-ones.
- Mispredict is actual != res_pred_taken. On mispredict, at the next edge:
  - flush=1
  - redirect_pc = actual ? res_target : res_pc+4 (32-bit wrap)
  - mispred_count increments, saturating
- flush and illegal_br are single-cycle pulses. Back-to-back mispredicts produce flush high on consecutive cycles, each with its own redirect_pc.
- redirect_pc holds its last value when flush=0.
- Same-index lookup and update in one cycle: pred_taken returns the pre-update value (read-before-write). The new value is visible the next cycle.
- res_valid=0: no state changes except flush and illegal_br returning to 0.
- Reset asserted mid-stream: table and counters clear at that edge. A flush pending from the previous cycle is dropped (flush=0 during and after reset).

Test Plan:
1. Reset, then pred_pc=0x100 -> pred_taken=0. Drive res_funct3=000, BrEq=1, res_pred_taken=0, res_pc=0x100, res_target=0x200 -> next cycle flush=1, redirect_pc=0x200, mispred_count=1, br_count=1.
2. Repeat a taken resolution on 0x100 three times -> entry saturates at 11 and pred_taken=1. Then one not-taken -> entry=10, pred_taken still 1.
3. res_funct3=110, BrLt=1 -> BrUn=1 in the same cycle, branch taken. res_funct3=101, BrLt=1 -> BrUn=0, not taken. With res_pred_taken=1 and res_pc=0xFFFFFFFC -> redirect_pc=0x00000000.
4. res_funct3=011, res_valid=1 -> illegal_br pulse, flush=0, counters unchanged, entry unchanged.
5. pred_pc=res_pc=0x40 in the same cycle as a taken update from 01 -> pred_taken=0 that cycle and 1 the following cycle.
6. Mispredict in cycle N with rst_n=0 in cycle N+1 -> flush=0 after reset, all counters 0, pred_taken=0 for any PC.

Source files
------------

// File: rtl/branch_resolver.sv
// Branch resolution unit: drives the comparator select, resolves the outcome,
// trains a PC-indexed table of 2-bit saturating counters, and flags mispredicts.
module branch_resolver #(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pred_pc,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic [31:0]      res_pc,
  input  logic [2:0]       res_funct3,
  input  logic             res_pred_taken,
  input  logic [31:0]      res_target,
  output logic             BrUn,
  input  logic             BrEq,
  input  logic             BrLt,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic             illegal_br,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int unsigned Entries = 2 ** IDX_BITS;

  logic [1:0]          table_q [Entries];
  logic [1:0]          table_d [Entries];
  logic                flush_q, flush_d;
  logic [31:0]         redirect_pc_q, redirect_pc_d;
  logic                illegal_br_q, illegal_br_d;
  logic [CNT_W-1:0]    br_count_q, br_count_d;
  logic [CNT_W-1:0]    mispred_count_q, mispred_count_d;

  logic [IDX_BITS-1:0] pred_idx, res_idx;
  logic                actual, illegal, legal, mispred;
  logic [1:0]          entry;

  assign pred_idx   = pred_pc[IDX_BITS+1:2];
  assign res_idx    = res_pc[IDX_BITS+1:2];
  // Read-before-write: lookup sees the registered entry, never table_d.
  assign pred_taken = table_q[pred_idx][1];
  assign BrUn       = (res_funct3 == 3'b110) || (res_funct3 == 3'b111);

  always_comb begin
    actual  = 1'b0;
    illegal = 1'b0;
    case (res_funct3)
      3'b000:  actual = BrEq;
      3'b001:  actual = !BrEq;
      3'b100:  actual = BrLt;
      3'b101:  actual = !BrLt;
      3'b110:  actual = BrLt;
      3'b111:  actual = !BrLt;
      default: illegal = 1'b1;
    endcase
  end

  assign legal   = res_valid && !illegal;
  assign mispred = legal && (actual != res_pred_taken);
  assign entry   = table_q[res_idx];

  always_comb begin
    table_d         = table_q;
    flush_d         = mispred;
    redirect_pc_d   = redirect_pc_q;
    illegal_br_d    = res_valid && illegal;
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (legal) begin
      if (actual && entry != 2'b11) begin
        table_d[res_idx] = entry + 2'd1;
      end else if (!actual && entry != 2'b00) begin
        table_d[res_idx] = entry - 2'd1;
      end
      if (br_count_q != '1) begin
        br_count_d = br_count_q + 1'b1;
      end
    end
    if (mispred) begin
      redirect_pc_d = actual ? res_target : res_pc + 32'd4;
      if (mispred_count_q != '1) begin
        mispred_count_d = mispred_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < Entries; i++) begin
        table_q[i] <= 2'b01;
      end
      flush_q         <= 1'b0;
      redirect_pc_q   <= '0;
      illegal_br_q    <= 1'b0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      table_q         <= table_d;
      flush_q         <= flush_d;
      redirect_pc_q   <= redirect_pc_d;
      illegal_br_q    <= illegal_br_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign flush         = flush_q;
  assign redirect_pc   = redirect_pc_q;
  assign illegal_br    = illegal_br_q;
  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule
